collatz_sweep_ctrl: RTL and testbench



---
 rtl/collatz_sweep_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_collatz_sweep_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collatz_sweep_ctrl.sv
// Sweeps one Collatz engine across seeds [base, base+count), tracking
// the longest orbit and highest peak with the seeds that produced them.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   cfg_start         start pulse (IDLE only), samples cfg_base/cfg_count
//   host_abort        stop the sweep; partial results are kept
//   eng_start/number  one-cycle launch of the engine on a seed
//   eng_abort         one-cycle drop request to the engine
//   eng_done/orbit_len/path_record  engine completion and results
//   busy, done        sweep in progress / one-cycle end pulse
//   aborted           last sweep ended by host_abort
//   best_len/seed     longest orbit and its seed
//   best_peak/peak_seed highest path record and its seed
//   seeds_done        seeds finished, skipped or timed out
//   timeouts          seeds abandoned by the watchdog
module collatz_sweep_ctrl #(
  parameter int unsigned BITS         = 32,
  parameter int unsigned TIMEOUT_BITS = 16,
  parameter int unsigned MAX_CYCLES   = 65535
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_start,
  input  logic [BITS-1:0] cfg_base,
  input  logic [BITS-1:0] cfg_count,
  input  logic            host_abort,
  output logic            eng_start,
  output logic            eng_abort,
  output logic [BITS-1:0] eng_number,
  input  logic            eng_done,
  input  logic [BITS-1:0] eng_orbit_len,
  input  logic [BITS-1:0] eng_path_record,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic [BITS-1:0] best_len,
  output logic [BITS-1:0] best_seed,
  output logic [BITS-1:0] best_peak,
  output logic [BITS-1:0] peak_seed,
  output logic [BITS-1:0] seeds_done,
  output logic [BITS-1:0] timeouts
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_UPDATE,
    S_FINISH
  } state_t;

  localparam logic [TIMEOUT_BITS-1:0] WD_LAST =
    TIMEOUT_BITS'(MAX_CYCLES - 1);

  state_t state;
  state_t state_nxt;

  logic [BITS-1:0]         seed;
  logic [BITS-1:0]         remaining;
  logic [TIMEOUT_BITS-1:0] wdog;
  logic [BITS-1:0]         held_len;
  logic [BITS-1:0]         held_peak;
  logic                    held_valid;

  logic accept;
  logic launch;
  logic capture;
  logic expire;
  logic advance;
  logic abort_hit;

  assign eng_number = seed;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    eng_start = 1'b0;
    eng_abort = 1'b0;
    accept    = 1'b0;
    launch    = 1'b0;
    capture   = 1'b0;
    expire    = 1'b0;
    advance   = 1'b0;
    abort_hit = 1'b0;
    busy      = (state != S_IDLE);
    done      = (state == S_FINISH);
    unique case (state)
      S_IDLE: begin
        if (cfg_start) begin
          accept    = 1'b1;
          state_nxt = (cfg_count == '0) ? S_FINISH : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        launch = 1'b1;
        if (host_abort) begin
          abort_hit = 1'b1;
          state_nxt = S_FINISH;
        end else if (seed == '0) begin
          // seed 0 has no orbit: skip without touching the engine
          state_nxt = S_UPDATE;
        end else begin
          eng_start = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (host_abort) begin
          eng_abort = 1'b1;
          abort_hit = 1'b1;
          state_nxt = S_FINISH;
        end else if (eng_done) begin
          // a result arriving on the last watchdog cycle still counts
          capture   = 1'b1;
          state_nxt = S_UPDATE;
        end else if (wdog == WD_LAST) begin
          eng_abort = 1'b1;
          expire    = 1'b1;
          state_nxt = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (host_abort) begin
          abort_hit = 1'b1;
          state_nxt = S_FINISH;
        end else begin
          advance   = 1'b1;
          state_nxt = (remaining == BITS'(1)) ? S_FINISH : S_LAUNCH;
        end
      end
      S_FINISH: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seed       <= '0;
      remaining  <= '0;
      wdog       <= '0;
      held_len   <= '0;
      held_peak  <= '0;
      held_valid <= 1'b0;
      aborted    <= 1'b0;
      best_len   <= '0;
      best_seed  <= '0;
      best_peak  <= '0;
      peak_seed  <= '0;
      seeds_done <= '0;
      timeouts   <= '0;
    end else begin
      if (accept) begin
        seed       <= cfg_base;
        remaining  <= cfg_count;
        held_valid <= 1'b0;
        aborted    <= 1'b0;
        best_len   <= '0;
        best_seed  <= '0;
        best_peak  <= '0;
        peak_seed  <= '0;
        seeds_done <= '0;
        timeouts   <= '0;
      end

      if (launch) begin
        wdog       <= '0;
        held_valid <= 1'b0;
      end

      if (state == S_WAIT) begin
        wdog <= wdog + 1'b1;
      end

      if (capture) begin
        held_len   <= eng_orbit_len;
        held_peak  <= eng_path_record;
        held_valid <= 1'b1;
      end

      if (expire) begin
        timeouts <= timeouts + 1'b1;
      end

      if (abort_hit) begin
        aborted <= 1'b1;
      end

      if (advance) begin
        // strict compares keep the earliest seed on ties
        if (held_valid && (held_len > best_len)) begin
          best_len  <= held_len;
          best_seed <= seed;
        end
        if (held_valid && (held_peak > best_peak)) begin
          best_peak <= held_peak;
          peak_seed <= seed;
        end
        seeds_done <= seeds_done + 1'b1;
        remaining  <= remaining - 1'b1;
        seed       <= seed + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_collatz_sweep_ctrl.sv
// Self-checking bench for collatz_sweep_ctrl with a behavioural engine.
// Ports: none (top-level bench).
module tb_collatz_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_start;
  logic [31:0] cfg_base;
  logic [31:0] cfg_count;
  logic        host_abort;
  logic        eng_start;
  logic        eng_abort;
  logic [31:0] eng_number;
  logic        eng_done = 1'b0;
  logic [31:0] eng_orbit_len = '0;
  logic [31:0] eng_path_record = '0;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [31:0] best_len;
  logic [31:0] best_seed;
  logic [31:0] best_peak;
  logic [31:0] peak_seed;
  logic [31:0] seeds_done;
  logic [31:0] timeouts;

  always #5 clk = ~clk;

  collatz_sweep_ctrl #(
    .BITS(32),
    .TIMEOUT_BITS(16),
    .MAX_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_start(cfg_start),
    .cfg_base(cfg_base),
    .cfg_count(cfg_count),
    .host_abort(host_abort),
    .eng_start(eng_start),
    .eng_abort(eng_abort),
    .eng_number(eng_number),
    .eng_done(eng_done),
    .eng_orbit_len(eng_orbit_len),
    .eng_path_record(eng_path_record),
    .busy(busy),
    .done(done),
    .aborted(aborted),
    .best_len(best_len),
    .best_seed(best_seed),
    .best_peak(best_peak),
    .peak_seed(peak_seed),
    .seeds_done(seeds_done),
    .timeouts(timeouts)
  );

  function automatic logic [31:0] c_steps(input logic [31:0] n);
    longint unsigned x;
    int s;
    x = 64'(n);
    s = 0;
    while (x > 1 && s < 100000) begin
      x = x[0] ? 3 * x + 1 : x >> 1;
      s++;
    end
    return 32'(s);
  endfunction

  function automatic logic [31:0] c_peak(input logic [31:0] n);
    longint unsigned x;
    longint unsigned p;
    int s;
    x = 64'(n);
    p = x;
    s = 0;
    while (x > 1 && s < 100000) begin
      x = x[0] ? 3 * x + 1 : x >> 1;
      if (x > p) p = x;
      s++;
    end
    if (p > 64'hFFFF_FFFF) p = 64'hFFFF_FFFF;
    return 32'(p);
  endfunction

  // engine: eng_done lands in the eng_lat-th WAIT cycle (eng_lat >= 2)
  int          eng_lat = 3;
  logic        hang_en = 1'b0;
  logic [31:0] hang_seed = '0;
  logic        e_pend = 1'b0;
  int          e_rem = 0;
  logic [31:0] e_num = '0;

  always @(posedge clk) begin
    eng_done <= 1'b0;
    if (reset || eng_abort) begin
      e_pend <= 1'b0;
    end else if (eng_start) begin
      e_num  <= eng_number;
      e_rem  <= eng_lat - 2;
      e_pend <= !(hang_en && eng_number == hang_seed);
    end else if (e_pend) begin
      if (e_rem == 0) begin
        eng_done        <= 1'b1;
        eng_orbit_len   <= c_steps(e_num);
        eng_path_record <= c_peak(e_num);
        e_pend          <= 1'b0;
      end else begin
        e_rem <= e_rem - 1;
      end
    end
  end

  int          launches = 0;
  int          done_cnt = 0;
  logic [31:0] launch_q[$];

  always @(negedge clk) begin
    if (eng_start) begin
      launches++;
      launch_q.push_back(eng_number);
    end
    if (done) done_cnt++;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_sweep(input logic [31:0] b, input logic [31:0] c);
    cfg_base  = b;
    cfg_count = c;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int n = 0; n < 3000 && !done; n++) step();
    chk(name, 32'(done), 32'd1);
  endtask

  typedef struct {
    logic [31:0] base;
    logic [31:0] count;
    int          lat;
    logic        hang;
    logic [31:0] hseed;
    logic [31:0] len;
    logic [31:0] lseed;
    logic [31:0] peak;
    logic [31:0] pseed;
    logic [31:0] sd;
    logic [31:0] to;
    int          nl;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int l0;
    int d0;
    int n;

    vecs[0] = '{32'd1,  32'd10, 3,  1'b0, 32'd0,
                32'd19, 32'd9,  32'd52, 32'd7,  32'd10, 32'd0, 10};
    vecs[1] = '{32'd26, 32'd3,  3,  1'b1, 32'd27,
                32'd18, 32'd28, 32'd52, 32'd28, 32'd3,  32'd1, 3};
    vecs[2] = '{32'd3,  32'd2,  16, 1'b0, 32'd0,
                32'd7,  32'd3,  32'd16, 32'd3,  32'd2,  32'd0, 2};
    vecs[3] = '{32'd6,  32'd3,  3,  1'b0, 32'd0,
                32'd16, 32'd7,  32'd52, 32'd7,  32'd3,  32'd0, 3};
    vecs[4] = '{32'd5,  32'd1,  2,  1'b0, 32'd0,
                32'd5,  32'd5,  32'd16, 32'd5,  32'd1,  32'd0, 1};

    reset      = 1'b1;
    cfg_start  = 1'b0;
    cfg_base   = '0;
    cfg_count  = '0;
    host_abort = 1'b0;
    step();
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_eng_start", 32'(eng_start), 0);
    chk("rst_aborted", 32'(aborted), 0);
    chk("rst_best_len", best_len, 0);
    chk("rst_best_peak", best_peak, 0);
    chk("rst_seeds_done", seeds_done, 0);
    chk("rst_timeouts", timeouts, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      eng_lat   = vecs[i].lat;
      hang_en   = vecs[i].hang;
      hang_seed = vecs[i].hseed;
      l0 = launches;
      start_sweep(vecs[i].base, vecs[i].count);
      wait_done($sformatf("v%0d_done", i));
      chk($sformatf("v%0d_busy", i), 32'(busy), 1);
      chk($sformatf("v%0d_best_len", i), best_len, vecs[i].len);
      chk($sformatf("v%0d_best_seed", i), best_seed, vecs[i].lseed);
      chk($sformatf("v%0d_best_peak", i), best_peak, vecs[i].peak);
      chk($sformatf("v%0d_peak_seed", i), peak_seed, vecs[i].pseed);
      chk($sformatf("v%0d_seeds_done", i), seeds_done, vecs[i].sd);
      chk($sformatf("v%0d_timeouts", i), timeouts, vecs[i].to);
      chk($sformatf("v%0d_launches", i), 32'(launches - l0),
          32'(vecs[i].nl));
      step();
      chk($sformatf("v%0d_idle", i), 32'(busy), 0);
    end
    hang_en = 1'b0;
    eng_lat = 3;

    // count=0: one FINISH cycle, no launch, results cleared
    l0 = launches;
    start_sweep(32'd5, 32'd0);
    chk("zero_busy", 32'(busy), 1);
    chk("zero_done", 32'(done), 1);
    chk("zero_best_len", best_len, 0);
    chk("zero_peak_seed", peak_seed, 0);
    step();
    chk("zero_busy_after", 32'(busy), 0);
    chk("zero_done_after", 32'(done), 0);
    chk("zero_launches", 32'(launches - l0), 0);

    // watchdog fires 16 cycles after seed 27 launches
    hang_en   = 1'b1;
    hang_seed = 32'd27;
    start_sweep(32'd26, 32'd3);
    n = 0;
    while (n < 200 && !(eng_start && eng_number == 32'd27)) begin
      step();
      n++;
    end
    chk("to_launch27", 32'(eng_start), 1);
    n = 0;
    for (int k = 0; k < 40 && !eng_abort; k++) begin
      step();
      n++;
    end
    chk("to_abort_delay", 32'(n), 32'd16);
    wait_done("to_done");
    chk("to_timeouts", timeouts, 1);
    step();
    hang_en = 1'b0;

    // base at the top of the range: wraps to 0, which is skipped
    l0 = launches;
    start_sweep(32'hFFFF_FFFF, 32'd2);
    wait_done("wrap_done");
    chk("wrap_launches", 32'(launches - l0), 1);
    chk("wrap_number", launch_q[l0], 32'hFFFF_FFFF);
    chk("wrap_seeds_done", seeds_done, 2);
    chk("wrap_best_seed", best_seed, 32'hFFFF_FFFF);
    chk("wrap_peak_seed", peak_seed, 32'hFFFF_FFFF);
    step();

    // host_abort 5 cycles into WAIT of the 3rd seed
    eng_lat = 10;
    l0 = launches;
    start_sweep(32'd1, 32'd10);
    n = 0;
    while (n < 200 && (launches - l0) < 3) begin
      step();
      n++;
    end
    chk("ha_third_launch", 32'(eng_start), 1);
    for (int k = 0; k < 5; k++) step();
    host_abort = 1'b1;
    #1;
    chk("ha_eng_abort", 32'(eng_abort), 1);
    step();
    host_abort = 1'b0;
    chk("ha_done", 32'(done), 1);
    chk("ha_aborted", 32'(aborted), 1);
    chk("ha_seeds_done", seeds_done, 2);
    chk("ha_best_len", best_len, 1);
    chk("ha_best_seed", best_seed, 2);
    step();
    chk("ha_idle", 32'(busy), 0);
    chk("ha_sticky", 32'(aborted), 1);
    eng_lat = 3;
    start_sweep(32'd3, 32'd1);
    chk("ha_cleared", 32'(aborted), 0);
    wait_done("ha_next_done");
    step();

    // coincident done/expiry, plus cfg_start pulsed mid-sweep
    eng_lat = 16;
    l0 = launches;
    start_sweep(32'd3, 32'd2);
    step();
    step();
    cfg_base  = 32'd100;
    cfg_count = 32'd50;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    wait_done("mid_done");
    chk("mid_launches", 32'(launches - l0), 2);
    chk("mid_seed0", launch_q[l0], 32'd3);
    chk("mid_seed1", launch_q[l0+1], 32'd4);
    chk("mid_timeouts", timeouts, 0);
    chk("mid_best_len", best_len, 7);
    step();

    // reset mid-sweep: no done pulse, everything cleared
    eng_lat = 3;
    d0 = done_cnt;
    start_sweep(32'd1, 32'd10);
    for (int k = 0; k < 8; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_seeds_done", seeds_done, 0);
    chk("mr_best_peak", best_peak, 0);
    step();
    step();
    chk("mr_no_done", 32'(done_cnt - d0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
